// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator with format classification, illegal-opcode
// flagging and PC-relative target precompute, behind a valid/ready output register plus skid.
module imm_gen_pipe #(
    parameter int XLEN = 32,
    parameter int PC_W = XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [PC_W-1:0] out_target
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic [PC_W-1:0] target;
    } beat_t;

    localparam bit RV64 = (XLEN == 64);

    fmt_e               fmt;
    logic               illegal;
    logic               pc_rel;
    logic               is_lui;
    logic signed [31:0] raw;
    beat_t              dec;

    beat_t or_q;
    beat_t sk_q;
    logic  or_valid;
    logic  sk_valid;
    logic  accept;

    // Every real opcode ends in 2'b11, so a bad inst[1:0] falls through to the default arm.
    // NOTE: every always_comb output gets a default first, otherwise a missed path infers a latch.
    always_comb begin
        fmt     = FMT_NONE;
        illegal = 1'b0;
        pc_rel  = 1'b0;
        is_lui  = 1'b0;
        case (in_inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt = FMT_I;
            7'b0011011: begin
                if (RV64) fmt = FMT_I;
                else      illegal = 1'b1;
            end
            7'b0100011: fmt = FMT_S;
            7'b1100011: begin
                fmt    = FMT_B;
                pc_rel = 1'b1;
            end
            7'b0110111: begin
                fmt    = FMT_U;
                is_lui = 1'b1;
            end
            7'b0010111: begin
                fmt    = FMT_U;
                pc_rel = 1'b1;
            end
            7'b1101111: begin
                fmt    = FMT_J;
                pc_rel = 1'b1;
            end
            7'b0110011, 7'b0001111: fmt = FMT_NONE;
            7'b0111011: illegal = !RV64;
            default:    illegal = 1'b1;
        endcase

        // 32-bit signed immediate; widening to XLEN/PC_W replicates inst[31].
        case (fmt)
            FMT_I:   raw = 32'($signed(in_inst[31:20]));
            FMT_S:   raw = 32'($signed({in_inst[31:25], in_inst[11:7]}));
            FMT_B:   raw = 32'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                        in_inst[11:8], 1'b0}));
            FMT_U:   raw = {in_inst[31:12], 12'b0};
            FMT_J:   raw = 32'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                        in_inst[30:21], 1'b0}));
            default: raw = '0;
        endcase

        dec.imm     = XLEN'(raw);
        dec.fmt     = fmt;
        dec.illegal = illegal;
        if (pc_rel)      dec.target = in_pc + PC_W'(raw);
        else if (is_lui) dec.target = PC_W'(raw);
        else             dec.target = '0;
    end

    // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally.
    assign in_ready = !sk_valid;
    assign accept   = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    // NOTE: payload registers are reset too, because the outputs must read zero while in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            or_valid <= 1'b0;
            sk_valid <= 1'b0;
            or_q     <= '0;
            sk_q     <= '0;
        end else if (flush) begin
            or_valid <= 1'b0;
            sk_valid <= 1'b0;
        end else if (!or_valid || out_ready) begin
            // Output slot frees up this cycle: refill from skid first to keep order.
            if (sk_valid) begin
                or_q     <= sk_q;
                or_valid <= 1'b1;
                sk_valid <= accept;
                if (accept) sk_q <= dec;
            end else begin
                or_valid <= accept;
                if (accept) or_q <= dec;
            end
        end else if (accept) begin
            sk_q     <= dec;
            sk_valid <= 1'b1;
        end
    end

    assign out_valid   = or_valid;
    assign out_imm     = or_q.imm;
    assign out_fmt     = or_q.fmt;
    assign out_illegal = or_q.illegal;
    assign out_target  = or_q.target;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances side by side,
// directed cases plus a randomized run against an arithmetic reference model.
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [63:0] tgt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_inst;
    logic [63:0] pc;

    logic        rdy32, v32, ill32;
    logic [31:0] imm32, tgt32;
    logic [2:0]  fmt32;
    logic        rdy64, v64, ill64;
    logic [63:0] imm64, tgt64;
    logic [2:0]  fmt64;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb [2][$];
    bit   hold [2];
    exp_t held [2];
    int   fired [2];

    logic [6:0] ops [15] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h1B, 7'h23, 7'h63, 7'h37,
                             7'h17, 7'h6F, 7'h33, 7'h0F, 7'h3B, 7'h0B, 7'h7F};

    imm_gen_pipe #(.XLEN(32)) d32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_inst(in_inst), .in_pc(pc[31:0]),
        .out_valid(v32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
        .out_illegal(ill32), .out_target(tgt32)
    );

    imm_gen_pipe #(.XLEN(64)) d64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_inst(in_inst), .in_pc(pc),
        .out_valid(v64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
        .out_illegal(ill64), .out_target(tgt64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: immediates as signed integers assembled from instruction fields.
    function automatic exp_t model(logic [31:0] inst, logic [63:0] p, bit x64);
        exp_t   e;
        longint v;
        bit     pcrel, lui;
        e = '0; v = 0; pcrel = 0; lui = 0;
        case (inst[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: e.fmt = 3'd1;
            7'h1B: if (x64) e.fmt = 3'd1; else e.ill = 1'b1;
            7'h23: e.fmt = 3'd2;
            7'h63: begin e.fmt = 3'd3; pcrel = 1; end
            7'h37: begin e.fmt = 3'd4; lui = 1; end
            7'h17: begin e.fmt = 3'd4; pcrel = 1; end
            7'h6F: begin e.fmt = 3'd5; pcrel = 1; end
            7'h33, 7'h0F: e.fmt = 3'd0;
            7'h3B: e.ill = !x64;
            default: e.ill = 1'b1;
        endcase
        case (e.fmt)
            3'd1: begin
                v = longint'(inst[31:20]);
                if (v >= 2048) v -= 4096;
            end
            3'd2: begin
                v = longint'(inst[31:25]) * 32 + longint'(inst[11:7]);
                if (v >= 2048) v -= 4096;
            end
            3'd3: begin
                v = longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048
                  + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
                if (v >= 4096) v -= 8192;
            end
            3'd4: begin
                v = longint'(inst[31:12]) * 4096;
                if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000;
            end
            3'd5: begin
                v = longint'(inst[31]) * 1048576 + longint'(inst[19:12]) * 4096
                  + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
                if (v >= 1048576) v -= 2097152;
            end
            default: v = 0;
        endcase
        e.imm = v;
        if (pcrel)    e.tgt = p + v;
        else if (lui) e.tgt = v;
        else          e.tgt = '0;
        if (!x64) begin
            e.imm = {32'b0, e.imm[31:0]};
            e.tgt = {32'b0, e.tgt[31:0]};
        end
        return e;
    endfunction

    task automatic get_obs(int d, output logic v, output logic r, output exp_t o);
        if (d == 0) begin
            v = v32; r = rdy32;
            o.imm = {32'b0, imm32}; o.fmt = fmt32; o.ill = ill32; o.tgt = {32'b0, tgt32};
        end else begin
            v = v64; r = rdy64;
            o.imm = imm64; o.fmt = fmt64; o.ill = ill64; o.tgt = tgt64;
        end
    endtask

    // Score the upcoming clock edge from current (settled) signals, then advance past it.
    task automatic cycle();
        logic ov, ordy;
        exp_t o, e;
        string n;
        for (int d = 0; d < 2; d++) begin
            get_obs(d, ov, ordy, o);
            n = (d == 0) ? "x32" : "x64";
            if (hold[d]) begin
                check({n, " hold valid"}, ov, 1);
                check({n, " hold imm"}, o.imm, held[d].imm);
                check({n, " hold fmt"}, o.fmt, held[d].fmt);
                check({n, " hold illegal"}, o.ill, held[d].ill);
                check({n, " hold target"}, o.tgt, held[d].tgt);
            end
            if (flush) begin
                sb[d].delete();
                hold[d] = 0;
            end else begin
                if (ov && out_ready) begin
                    check({n, " beat expected"}, sb[d].size() > 0, 1);
                    if (sb[d].size() > 0) begin
                        e = sb[d].pop_front();
                        check({n, " imm"}, o.imm, e.imm);
                        check({n, " fmt"}, o.fmt, e.fmt);
                        check({n, " illegal"}, o.ill, e.ill);
                        check({n, " target"}, o.tgt, e.tgt);
                        fired[d]++;
                    end
                end
                if (in_valid && ordy)
                    sb[d].push_back(model(in_inst, (d == 0) ? {32'b0, pc[31:0]} : pc, d == 1));
                hold[d] = ov && !out_ready;
                held[d] = o;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit v, logic [31:0] i, logic [63:0] p);
        in_valid = v;
        in_inst  = i;
        pc       = p;
    endtask

    task automatic send_one(logic [31:0] i, logic [63:0] p);
        drive(1, i, p);
        cycle();
        drive(0, 32'h0, 64'h0);
    endtask

    task automatic drain(int budget);
        for (int k = 0; k < budget && (sb[0].size() != 0 || sb[1].size() != 0); k++) cycle();
        check("drain x32 leftover", sb[0].size(), 0);
        check("drain x64 leftover", sb[1].size(), 0);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 9) == 0) return r;
        return {r[31:7], ops[$urandom_range(0, 14)]};
    endfunction

    initial begin
        int f0;
        bit took;
        reset = 0; flush = 0; out_ready = 1;
        drive(0, 32'h0, 64'h0);
        hold[0] = 0; hold[1] = 0; fired[0] = 0; fired[1] = 0;
        #12;
        check("reset valid", v32, 0);
        check("reset imm", imm64, 0);
        check("reset fmt", fmt32, 0);
        check("reset illegal", ill64, 0);
        check("reset target", tgt32, 0);
        check("reset in_ready", rdy32, 1);
        @(posedge clk); #1;
        reset = 1;

        // Back-to-back stream at pc 0.
        drive(1, 32'hFFF00093, 64'h0); cycle();
        check("addi valid", v32, 1);
        check("addi imm", imm32, 32'hFFFFFFFF);
        check("addi fmt", fmt32, 1);
        drive(1, 32'hFE112E23, 64'h0); cycle();
        check("sw imm", imm32, 32'hFFFFFFFC);
        check("sw fmt", fmt32, 2);
        drive(1, 32'h123452B7, 64'h0); cycle();
        check("lui imm", imm32, 32'h12345000);
        check("lui fmt", fmt32, 4);
        check("lui target", tgt32, 32'h12345000);
        drive(0, 32'h0, 64'h0); cycle();
        check("stream done valid", v32, 0);

        send_one(32'hFF9FF0EF, 64'h100);
        check("jal imm", imm32, 32'hFFFFFFF8);
        check("jal fmt", fmt32, 5);
        check("jal target", tgt32, 32'h000000F8);
        check("jal x64 imm", imm64, 64'hFFFFFFFFFFFFFFF8);
        send_one(32'h800002B7, 64'h0);
        check("lui x64 imm", imm64, 64'hFFFFFFFF80000000);
        check("lui x32 imm", imm32, 32'h80000000);
        send_one(32'h0000009B, 64'h0);
        check("addiw x64 fmt", fmt64, 1);
        check("addiw x64 illegal", ill64, 0);
        check("addiw x32 illegal", ill32, 1);
        check("addiw x32 imm", imm32, 0);
        send_one(32'h0000000B, 64'h0);
        check("custom0 illegal", ill32, 1);
        check("custom0 fmt", fmt32, 0);
        check("custom0 imm", imm32, 0);
        send_one(32'h00000010, 64'h0);
        check("lowbits illegal", ill32, 1);
        cycle();

        // Backpressure: A to OR, B to skid, C held off until space frees.
        f0 = fired[0];
        out_ready = 0;
        drive(1, 32'h00500113, 64'h200); cycle();
        drive(1, 32'h0000006F, 64'h204); cycle();
        check("bp in_ready x32", rdy32, 0);
        check("bp in_ready x64", rdy64, 0);
        drive(1, 32'hFE000EE3, 64'h208); cycle(); cycle();
        out_ready = 1;
        took = 0;
        for (int k = 0; k < 10 && !took; k++) begin
            took = rdy32;
            cycle();
        end
        check("bp C accepted", took, 1);
        drive(0, 32'h0, 64'h0);
        drain(20);
        check("bp beat count", fired[0] - f0, 3);

        // Flush with OR and skid full plus an input beat.
        f0 = fired[0];
        out_ready = 0;
        drive(1, 32'h00A00093, 64'h300); cycle();
        drive(1, 32'h00B00093, 64'h304); cycle();
        drive(1, 32'h00C00093, 64'h308);
        flush = 1; cycle();
        flush = 0; drive(0, 32'h0, 64'h0);
        check("flush out_valid", v32, 0);
        check("flush in_ready", rdy32, 1);
        check("flush x64 out_valid", v64, 0);
        out_ready = 1;
        for (int k = 0; k < 4; k++) cycle();
        check("flush no beats", fired[0] - f0, 0);
        drive(1, 32'h00D00093, 64'h30C);
        flush = 1; cycle();
        flush = 0; drive(0, 32'h0, 64'h0);
        check("flush accept dropped", v32, 0);
        cycle();

        // Asynchronous reset mid-stream.
        out_ready = 0;
        drive(1, 32'h00100093, 64'h400); cycle();
        drive(1, 32'h7FF00113, 64'h404); cycle();
        drive(0, 32'h0, 64'h0);
        #2 reset = 0;
        #1;
        check("midrst valid", v32, 0);
        check("midrst imm", imm32, 0);
        check("midrst x64 target", tgt64, 0);
        check("midrst in_ready", rdy32, 1);
        sb[0].delete(); sb[1].delete(); hold[0] = 0; hold[1] = 0;
        @(posedge clk); #1;
        reset = 1; out_ready = 1;
        send_one(32'hFF9FF0EF, 64'h100);
        check("post reset valid", v32, 1);
        check("post reset target", tgt32, 32'h000000F8);
        cycle();

        // Randomized traffic with backpressure and occasional flushes.
        for (int k = 0; k < 400; k++) begin
            flush = ($urandom_range(0, 31) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 3) != 0, rand_inst(), {$urandom, $urandom});
            cycle();
        end
        flush = 0; out_ready = 1;
        drive(0, 32'h0, 64'h0);
        drain(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
